// File: rtl/openframe_gpio_ctrl.sv
// Memory-mapped GPIO controller for the openframe pad ring: output data, per-pad
// configuration, synchronized inputs with rising-edge capture and a level interrupt.
module openframe_gpio_ctrl #(
  parameter int unsigned NPADS    = 44,
  parameter logic [23:0] BASE_SEL = 24'h030000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [NPADS-1:0] gpio_in,
  output logic [NPADS-1:0] gpio_out,
  output logic [NPADS-1:0] gpio_oeb,
  output logic [NPADS-1:0] gpio_ieb,
  output logic [NPADS-1:0] gpio_ib_mode_sel,
  output logic [NPADS-1:0] gpio_vtrip_sel,
  output logic [NPADS-1:0] gpio_slow_sel,
  output logic [NPADS-1:0] gpio_dm2,
  output logic [NPADS-1:0] gpio_dm1,
  output logic [NPADS-1:0] gpio_dm0,
  output logic             irq
);
  localparam int unsigned RW = 64;

  localparam logic [7:0] OFF_OUT_LO  = 8'h00;
  localparam logic [7:0] OFF_OUT_HI  = 8'h04;
  localparam logic [7:0] OFF_IN_LO   = 8'h08;
  localparam logic [7:0] OFF_IN_HI   = 8'h0C;
  localparam logic [7:0] OFF_PAD_SEL = 8'h10;
  localparam logic [7:0] OFF_PAD_CFG = 8'h14;
  localparam logic [7:0] OFF_EDGE_LO = 8'h18;
  localparam logic [7:0] OFF_EDGE_HI = 8'h1C;
  localparam logic [7:0] OFF_IEN_LO  = 8'h20;
  localparam logic [7:0] OFF_IEN_HI  = 8'h24;

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_GAP} state_t;

  state_t            state_q, state_d;
  logic              sel_c, accept_c, commit_c;
  logic [7:0]        req_off;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic [NPADS-1:0]  sync1, sync2, prev, edge_q, ien_q;
  logic [5:0]        pad_sel;
  logic [1:0]        warm;
  logic              pad_ok_c;
  logic [7:0]        cfg_rd_c;
  logic [31:0]       rd_c, byte_mask_c;
  logic [RW-1:0]     out_w, in_w, edge_w, ien_w, wr_mask_c, wr_data_c;
  logic              wr_out_c, wr_edge_c, wr_ien_c;
  logic [NPADS-1:0]  out_nx_c, ien_nx_c, edge_clr_c, rise_c, edge_nx_c;

  assign sel_c    = iomem_valid && (iomem_addr[31:8] == BASE_SEL);
  assign out_w    = RW'(gpio_out);
  assign in_w     = RW'(sync2);
  assign edge_w   = RW'(edge_q);
  assign ien_w    = RW'(ien_q);
  assign pad_ok_c = 32'(pad_sel) < NPADS;

  // Handshake: accept, acknowledge, then one mandatory idle cycle
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: if (sel_c) begin
        accept_c = 1'b1;
        state_d  = ST_ACK;
      end
      ST_ACK: begin
        commit_c = |req_wstrb;
        state_d  = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    cfg_rd_c = '0;
    if (pad_ok_c)
      cfg_rd_c = {gpio_slow_sel[pad_sel], gpio_vtrip_sel[pad_sel], gpio_ib_mode_sel[pad_sel],
                  gpio_ieb[pad_sel], gpio_oeb[pad_sel], gpio_dm2[pad_sel], gpio_dm1[pad_sel],
                  gpio_dm0[pad_sel]};
  end

  always_comb begin
    rd_c = '0;
    case (iomem_addr[7:0])
      OFF_OUT_LO:  rd_c = out_w[31:0];
      OFF_OUT_HI:  rd_c = out_w[63:32];
      OFF_IN_LO:   rd_c = in_w[31:0];
      OFF_IN_HI:   rd_c = in_w[63:32];
      OFF_PAD_SEL: rd_c = 32'(pad_sel);
      OFF_PAD_CFG: rd_c = 32'(cfg_rd_c);
      OFF_EDGE_LO: rd_c = edge_w[31:0];
      OFF_EDGE_HI: rd_c = edge_w[63:32];
      OFF_IEN_LO:  rd_c = ien_w[31:0];
      OFF_IEN_HI:  rd_c = ien_w[63:32];
      default:     rd_c = '0;
    endcase
  end

  // Lo/hi register pairs share one 64-bit byte-masked write path
  always_comb begin
    byte_mask_c = {{8{req_wstrb[3]}}, {8{req_wstrb[2]}}, {8{req_wstrb[1]}}, {8{req_wstrb[0]}}};
    wr_mask_c   = '0;
    wr_data_c   = '0;
    case (req_off)
      OFF_OUT_LO, OFF_EDGE_LO, OFF_IEN_LO: begin
        wr_mask_c = RW'(byte_mask_c);
        wr_data_c = RW'(req_wdata);
      end
      OFF_OUT_HI, OFF_EDGE_HI, OFF_IEN_HI: begin
        wr_mask_c = {byte_mask_c, 32'h0};
        wr_data_c = {req_wdata, 32'h0};
      end
      default: ;
    endcase
  end

  assign wr_out_c   = commit_c && (req_off == OFF_OUT_LO  || req_off == OFF_OUT_HI);
  assign wr_edge_c  = commit_c && (req_off == OFF_EDGE_LO || req_off == OFF_EDGE_HI);
  assign wr_ien_c   = commit_c && (req_off == OFF_IEN_LO  || req_off == OFF_IEN_HI);
  assign out_nx_c   = NPADS'((out_w & ~wr_mask_c) | (wr_data_c & wr_mask_c));
  assign ien_nx_c   = NPADS'((ien_w & ~wr_mask_c) | (wr_data_c & wr_mask_c));
  assign edge_clr_c = wr_edge_c ? NPADS'(wr_data_c & wr_mask_c) : '0;
  // Edges are masked until the synchronizer has refilled after reset
  assign rise_c     = sync2 & ~prev & {NPADS{warm == 2'd3}};
  assign edge_nx_c  = (edge_q & ~edge_clr_c) | rise_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      req_off     <= '0;
      req_wdata   <= '0;
      req_wstrb   <= '0;
    end else begin
      iomem_ready <= accept_c;
      iomem_rdata <= accept_c ? rd_c : '0;
      if (accept_c) begin
        req_off   <= iomem_addr[7:0];
        req_wdata <= iomem_wdata;
        req_wstrb <= iomem_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      warm  <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out         <= '0;
      gpio_oeb         <= '1;
      gpio_ieb         <= '0;
      gpio_ib_mode_sel <= '0;
      gpio_vtrip_sel   <= '0;
      gpio_slow_sel    <= '0;
      gpio_dm2         <= '0;
      gpio_dm1         <= '0;
      gpio_dm0         <= '1;
      pad_sel          <= '0;
      edge_q           <= '0;
      ien_q            <= '0;
      irq              <= 1'b0;
    end else begin
      if (wr_out_c) gpio_out <= out_nx_c;
      if (wr_ien_c) ien_q <= ien_nx_c;
      edge_q <= edge_nx_c;
      irq    <= |(edge_q & ien_q);
      if (commit_c && req_off == OFF_PAD_SEL && req_wstrb[0]) pad_sel <= req_wdata[5:0];
      if (commit_c && req_off == OFF_PAD_CFG && req_wstrb[0] && pad_ok_c) begin
        gpio_dm0[pad_sel]         <= req_wdata[0];
        gpio_dm1[pad_sel]         <= req_wdata[1];
        gpio_dm2[pad_sel]         <= req_wdata[2];
        gpio_oeb[pad_sel]         <= req_wdata[3];
        gpio_ieb[pad_sel]         <= req_wdata[4];
        gpio_ib_mode_sel[pad_sel] <= req_wdata[5];
        gpio_vtrip_sel[pad_sel]   <= req_wdata[6];
        gpio_slow_sel[pad_sel]    <= req_wdata[7];
      end
    end
  end
endmodule
